axi_taint_source: RTL
=====================

# axi_taint_source

Passive monitor on an AXI4 read channel that marks returning read data as tainted when the originating AR request falls inside one of several configurable address windows. It is the multi-window, multi-outstanding successor to the single-window, single-ID taint source, and sits beside the memory AXI port of the fuzzing harness. It tracks outstanding bursts per ID in order and drives a per-beat taint mask for the R channel. It also exposes sticky error flags for bookkeeping loss.

## Interface
- `ADDR_WIDTH`, 32, AR address width.
- `ID_WIDTH`, 4, AXI ID width; 2^ID_WIDTH per-ID queues.
- `DATA_WIDTH`, 64, R data width; width of the taint mask.
- `DEPTH`, 4, outstanding bursts tracked per ID (power of two, ≥2).
- `NUM_WIN`, 2, number of taint windows (1..8).
- `WIN_BASE`, {32'h80005000, 32'h80004000}, packed NUM_WIN×ADDR_WIDTH inclusive bases; window i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `WIN_LIMIT`, {32'h80006000, 32'h80005000}, packed exclusive limits, same layout.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `taint_en`  in  1  global enable; sampled at AR handshake.
- `ar_valid`, `ar_ready`  in  1  AR handshake.
- `ar_id`  in  ID_WIDTH  AR ID.
- `ar_addr`  in  ADDR_WIDTH  AR start address.
- `r_valid`, `r_ready`  in  1  R handshake.
- `r_id`  in  ID_WIDTH  R ID.
- `r_last`  in  1  last beat of burst.
- `r_taint`  out  DATA_WIDTH  taint mask for current R beat.
- `overflow`  out  1  sticky: AR accepted while its ID queue full.
- `orphan`  out  1  sticky: R beat accepted while its ID queue empty.
- `win_hits`  out  NUM_WIN  sticky per-window hit flags.
- `taint_beats`  out  32  tainted-beat count (only with `AXI_TAINT_SOURCE_STATS_EN`).

## Operation
- Per ID: circular FIFO of DEPTH 1-bit "hit" entries; read/write pointers plus count (log2(DEPTH)+1 bits).
- AR fire (`ar_valid & ar_ready`): hit = `taint_en` & OR over i of (`ar_addr` ≥ base_i & `ar_addr` < limit_i), unsigned compare. Push hit into queue `ar_id`; set `win_hits[i]` for each matching window (if `taint_en`).
- R fire (`r_valid & r_ready`): `r_taint` = all ones if queue `r_id` non-empty and head hit = 1, else 0. Pop head when `r_last` = 1; otherwise head retained for remaining beats.
- `r_taint` = 0 whenever R not firing.
- Full queue + AR fire: entry dropped, pointers unchanged, `overflow` ← 1.
- Empty queue + R fire: `r_taint` = 0, no pop, `orphan` ← 1.
- Simultaneous push and pop on same ID: both applied; count unchanged; pop consumes old head. If queue was full, push is accepted (pop frees slot same edge). If queue was empty, pop is orphan and push lands.
- Overlapping windows: hit if any matches; all matching `win_hits` bits set.
- Pointers wrap modulo DEPTH.

## Timing
- Push visible at head from the cycle after the AR fire edge; an R beat in the same cycle as its own AR is treated as orphan.
- `r_taint` combinational from `r_valid`, `r_ready`, `r_id`, and registered queue state; zero-cycle latency to the beat.
- Sticky flags register on the edge of the offending handshake; visible next cycle.
- Reset (any time, asynchronous assert): all pointers/counts 0, all hit bits 0, `overflow`=0, `orphan`=0, `win_hits`=0, `taint_beats`=0. `r_taint` = 0 while reset is low. In-flight bursts are forgotten; their later beats raise `orphan`.
- Flags clear only by reset.

## Configuration
- `AXI_TAINT_SOURCE_STATS_EN` defined: `taint_beats` port and a 32-bit counter are present. The counter increments on each R fire with nonzero `r_taint`, and saturates at 32'hFFFFFFFF.
- Not defined: `taint_beats` port and counter are absent; all other behaviour is identical.

## Test plan
- AR id 3, addr 0x80004010, then 4-beat R id 3, last on beat 4 → `r_taint`=all ones on all 4 beats; queue 3 empty afterwards; `win_hits`=2'b01.
- AR id 1 addr 0x80000000, then AR id 1 addr 0x80005800; two 2-beat bursts id 1 → first burst taint 0, second all ones; `win_hits`=2'b10.
- Interleaved: AR id 0 hit, AR id 5 miss; R id 5 beat (last), then R id 0 beat (last) → 0 then all ones, independent of issue order.
- Five ARs id 2 with no R (DEPTH=4) → `overflow`=1 after 5th; the following 4 bursts are returned with the correct taint, and a 5th burst raises `orphan`=1.
- `taint_en`=0 at AR in window → burst untainted; `win_hits` unchanged. Assert reset mid-burst → all outputs 0 immediately; the remaining beat raises `orphan`.
- With STATS_EN: three tainted single-beat bursts and one clean one → `taint_beats`=3.

Source files
------------

// File: rtl/axi_taint_source.sv
// Passive AXI4 read-channel monitor: tags R beats whose originating AR hit one of NUM_WIN windows.
// Optional feature macro: AXI_TAINT_SOURCE_STATS_EN adds the taint_beats counter port.
module axi_taint_source #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NUM_WIN    = 2,
  parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_BASE  = {32'h80005000, 32'h80004000},
  parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_LIMIT = {32'h80006000, 32'h80005000}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  taint_en,
  input  logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic                  r_valid,
  input  logic                  r_ready,
  input  logic [ID_WIDTH-1:0]   r_id,
  input  logic                  r_last,
  output logic [DATA_WIDTH-1:0] r_taint,
  output logic                  overflow,
  output logic                  orphan,
  output logic [NUM_WIN-1:0]    win_hits
`ifdef AXI_TAINT_SOURCE_STATS_EN
  ,
  output logic [31:0]           taint_beats
`endif
);

  localparam int unsigned NUM_IDS = 1 << ID_WIDTH;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] hit_q  [NUM_IDS];
  logic [DEPTH-1:0] hit_d  [NUM_IDS];
  logic [PTR_W-1:0] wptr_q [NUM_IDS];
  logic [PTR_W-1:0] wptr_d [NUM_IDS];
  logic [PTR_W-1:0] rptr_q [NUM_IDS];
  logic [PTR_W-1:0] rptr_d [NUM_IDS];
  logic [CNT_W-1:0] cnt_q  [NUM_IDS];
  logic [CNT_W-1:0] cnt_d  [NUM_IDS];

  logic               overflow_q, overflow_d;
  logic               orphan_q, orphan_d;
  logic [NUM_WIN-1:0] win_hits_q, win_hits_d;

  logic               ar_fire_s, r_fire_s;
  logic [NUM_WIN-1:0] win_match_s;
  logic               ar_hit_s;
  logic               ar_full_s, r_empty_s, head_hit_s;
  logic               push_s, pop_s, taint_s;

  // Window decode on the AR address (inclusive base, exclusive limit, unsigned).
  always_comb begin
    win_match_s = '0;
    for (int w = 0; w < int'(NUM_WIN); w++) begin
      win_match_s[w] = (ar_addr >= WIN_BASE[w*ADDR_WIDTH +: ADDR_WIDTH]) &&
                       (ar_addr <  WIN_LIMIT[w*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    ar_hit_s = taint_en & (|win_match_s);
  end

  // Handshake qualification; a full queue still accepts a push when its head pops on the same edge.
  always_comb begin
    ar_fire_s  = ar_valid & ar_ready;
    r_fire_s   = r_valid & r_ready;
    r_empty_s  = (cnt_q[r_id] == '0);
    head_hit_s = hit_q[r_id][rptr_q[r_id]];
    ar_full_s  = (cnt_q[ar_id] == FULL_CNT);
    pop_s      = r_fire_s & r_last & ~r_empty_s;
    push_s     = ar_fire_s & (~ar_full_s | (pop_s & (r_id == ar_id)));
    taint_s    = r_fire_s & ~r_empty_s & head_hit_s & reset;
  end

  // Per-ID FIFO next state and sticky flag accumulation.
  always_comb begin
    for (int i = 0; i < int'(NUM_IDS); i++) begin
      logic push_i;
      logic pop_i;
      push_i    = push_s & (ar_id == ID_WIDTH'(i));
      pop_i     = pop_s & (r_id == ID_WIDTH'(i));
      wptr_d[i] = push_i ? wptr_q[i] + PTR_W'(1) : wptr_q[i];
      rptr_d[i] = pop_i ? rptr_q[i] + PTR_W'(1) : rptr_q[i];
      cnt_d[i]  = cnt_q[i] + CNT_W'(push_i) - CNT_W'(pop_i);
      for (int j = 0; j < int'(DEPTH); j++) begin
        hit_d[i][j] = (push_i && (wptr_q[i] == PTR_W'(j))) ? ar_hit_s : hit_q[i][j];
      end
    end
    overflow_d = overflow_q | (ar_fire_s & ~push_s);
    orphan_d   = orphan_q | (r_fire_s & r_empty_s);
    win_hits_d = win_hits_q | ((ar_fire_s & taint_en) ? win_match_s : {NUM_WIN{1'b0}});
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_IDS); i++) begin
        hit_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
      win_hits_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_IDS); i++) begin
        hit_q[i]  <= hit_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      overflow_q <= overflow_d;
      orphan_q   <= orphan_d;
      win_hits_q <= win_hits_d;
    end
  end

  assign r_taint  = {DATA_WIDTH{taint_s}};
  assign overflow = overflow_q;
  assign orphan   = orphan_q;
  assign win_hits = win_hits_q;

`ifdef AXI_TAINT_SOURCE_STATS_EN
  logic [31:0] beats_q, beats_d;

  // Saturating count of tainted R beats.
  always_comb begin
    if (taint_s && (beats_q != 32'hFFFF_FFFF)) begin
      beats_d = beats_q + 32'd1;
    end else begin
      beats_d = beats_q;
    end
  end

  // Tainted-beat counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beats_q <= 32'd0;
    end else begin
      beats_q <= beats_d;
    end
  end

  assign taint_beats = beats_q;
`endif

endmodule
